ipm_distributed_fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one distributed FIFO write port (SYNC_FIFO configuration) among NUM_REQ requesters. It grants one requester at a time for a burst of up to BURST_MAX beats. Each requester uses a valid/ready handshake. The granted requester's data is steered onto the FIFO write port, and the arbiter back-pressures on the FIFO full flag. It sits directly in front of the FIFO wr_data/wr_en inputs, with the FIFO clocked by the same clk.

---
 rtl/ipm_distributed_fifo_wr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ipm_distributed_fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready requesters.
// A grant lasts until req_last, BURST_MAX beats or a dropped valid; one IDLE cycle separates bursts.
module ipm_distributed_fifo_wr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_MAX   = 8,
   parameter int AF_HOLD     = 1,
   localparam int SRC_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic                          fifo_wr_en,
   output logic [SRC_W-1:0]              fifo_wr_src,
   input  logic                          fifo_full,
   input  logic                          fifo_almost_full,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t                r_state, w_state_nxt;
   logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
   logic [SRC_W-1:0]      r_src, w_src_nxt;
   logic [SRC_W-1:0]      r_last_grant, w_last_grant_nxt;
   logic [7:0]            r_beat_cnt, w_beat_cnt_nxt;
   logic [SRC_W-1:0]      w_winner;
   logic                  w_eligible;
   logic                  w_g_valid, w_g_last, w_beat;
   logic [DATA_WIDTH-1:0] w_g_data;
   int                    w_dist, w_best_dist;

   // Winner is the valid requester at the smallest rotational distance after last_grant.
   always_comb begin
      w_winner    = r_last_grant;
      w_best_dist = NUM_REQ;
      w_dist      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = (i + 2*NUM_REQ - int'(r_last_grant) - 1) % NUM_REQ;
         if (req_valid[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_winner    = SRC_W'(i);
         end
      end
   end

   always_comb begin
      w_g_valid = 1'b0;
      w_g_last  = 1'b0;
      w_g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_src == SRC_W'(i)) begin
            w_g_valid = req_valid[i];
            w_g_last  = req_last[i];
            w_g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_eligible = (|req_valid) && !fifo_full && !((AF_HOLD != 0) && fifo_almost_full);

   // Handshake: a beat moves when req_valid[g] and req_ready[g] are both high in BURST;
   // fifo_wr_en is exactly that beat, and req_ready[g] is low whenever fifo_full is high.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_src_nxt        = r_src;
      w_last_grant_nxt = r_last_grant;
      w_beat_cnt_nxt   = r_beat_cnt;
      w_beat           = 1'b0;
      req_ready        = '0;
      fifo_wr_en       = 1'b0;
      fifo_wr_data     = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_eligible) begin
               w_state_nxt      = ST_BURST;
               w_grant_nxt      = NUM_REQ'(1) << w_winner;
               w_src_nxt        = w_winner;
               w_last_grant_nxt = w_winner;
               w_beat_cnt_nxt   = 8'd0;
            end
         end
         ST_BURST: begin
            req_ready    = fifo_full ? '0 : r_grant;
            w_beat       = w_g_valid && !fifo_full;
            fifo_wr_en   = w_beat;
            fifo_wr_data = w_g_data;
            if (!w_g_valid) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
            end else if (w_beat) begin
               w_beat_cnt_nxt = r_beat_cnt + 8'd1;
               if (w_g_last || (r_beat_cnt + 8'd1 == 8'(BURST_MAX))) begin
                  w_state_nxt = ST_IDLE;
                  w_grant_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_src        <= '0;
         r_last_grant <= SRC_W'(NUM_REQ - 1);
         r_beat_cnt   <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_src        <= w_src_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_beat_cnt   <= w_beat_cnt_nxt;
      end
   end

   assign grant       = r_grant;
   assign fifo_wr_src = r_src;
   assign busy        = (r_state == ST_BURST);

endmodule
